// File: rtl/mips_fetch_unit.sv
// Purpose: MIPS instruction-fetch stage; owns the PC, reads imem over req/ack, hands words to decode.
// Latency: ack in cycle N -> instr_valid in N+1; decoder ready in cycle M -> next imem_req in M+1.
// Backpressure: holds one word until instr_ready; no new fetch is issued while a word is held.
// Ports: clock/reset; imem_req/imem_addr/imem_ack/imem_data (memory side);
//        instr/instr_pc/instr_valid/instr_ready (decode side); redirect/redirect_target;
//        err_misaligned (sticky), fetch_count (accepted instructions, wraps).
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        err_misaligned,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] count_q, count_d;

    // Redirect targets are always used word-aligned; the low bits only feed the error flag.
    logic [31:0] target_aligned;
    assign target_aligned = {redirect_target[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        count_d    = count_q;

        // IDLE lasts only the first cycle after reset, so redirects are only honoured afterwards.
        if (redirect && (state_q != S_IDLE) && (redirect_target[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            S_FETCH: begin
                if (redirect) begin
                    pc_d = target_aligned;
                    if (imem_ack) begin
                        // Wrong-path word dropped; request the target right away.
                        addr_d = target_aligned;
                    end else begin
                        // Request cannot be withdrawn: wait out its ack in DISCARD.
                        state_d = S_DISCARD;
                    end
                end else if (imem_ack) begin
                    instr_d    = imem_data;
                    instr_pc_d = addr_q;
                    valid_d    = 1'b1;
                    pc_d       = addr_q + 32'd4;
                    req_d      = 1'b0;
                    state_d    = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    pc_d = target_aligned;
                end
                if (imem_ack) begin
                    state_d = S_FETCH;
                    addr_d  = redirect ? target_aligned : pc_q;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    // Held word squashed; any same-cycle ready is void.
                    valid_d = 1'b0;
                    pc_d    = target_aligned;
                    addr_d  = target_aligned;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (instr_ready) begin
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_valid    = valid_q;
    assign err_misaligned = err_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Purpose: exercises mips_fetch_unit against a program-order model and a timed memory model.
// Latency: one step per clock; outputs sampled and inputs driven on the falling edge.
// Backpressure: decoder ready and memory ack latency are driven by the scenarios.
module tb_mips_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        err_misaligned;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // Program-order model: next PC the decoder should accept, accepted count, sticky error.
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    bit          exp_err;
    int          xfers;

    // Memory model state.
    int          lat;        // fixed ack latency in cycles; negative = random 0..3
    bit          spurious;   // inject acks while no request is outstanding
    bit          pending;
    int          wait_c;
    logic [31:0] pend_addr;

    mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .err_misaligned  (err_misaligned),
        .fetch_count     (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0001 + (a >> 2);
    endfunction

    // One clock: check memory protocol, answer memory, score decoder transfer, drive, advance.
    task automatic step(input bit rdy, input bit rd, input logic [31:0] tgt);
        bit          ack;
        logic [31:0] dat;
        ack = 1'b0;
        dat = 32'h0;
        if (pending) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
                errors++;
                $display("FAIL imem_req_hold got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, pend_addr);
            end
        end
        if (imem_req === 1'b1 && !pending) begin
            pending   = 1'b1;
            pend_addr = imem_addr;
            wait_c    = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        end
        if (pending) begin
            if (wait_c == 0) begin
                ack     = 1'b1;
                dat     = mem_word(pend_addr);
                pending = 1'b0;
            end else begin
                wait_c--;
            end
        end else if (spurious && $urandom_range(0, 3) == 0) begin
            ack = 1'b1;
            dat = 32'hDEAD_BEEF;
        end
        if (rd) begin
            exp_pc = {tgt[31:2], 2'b00};
            if (tgt[1:0] != 2'b00) exp_err = 1'b1;
        end else if (instr_valid === 1'b1 && rdy) begin
            checks++;
            if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL transfer got pc=%h instr=%h exp pc=%h instr=%h", instr_pc, instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc    = exp_pc + 32'd4;
            exp_count = exp_count + 32'd1;
            xfers++;
        end
        imem_ack        = ack;
        imem_data       = dat;
        instr_ready     = rdy;
        redirect        = rd;
        redirect_target = tgt;
        @(negedge clock);
        checks++;
        if (fetch_count !== exp_count || err_misaligned !== exp_err) begin
            errors++;
            $display("FAIL count_err got count=%0d err=%b exp count=%0d err=%b", fetch_count, err_misaligned, exp_count, exp_err);
        end
    endtask

    task automatic model_reset();
        exp_pc    = 32'h0;
        exp_count = 32'h0;
        exp_err   = 1'b0;
        pending   = 1'b0;
    endtask

    task automatic wait_hold(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (instr_valid === 1'b1) ok = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b1; imem_data = 32'hFFFF_FFFF;
        instr_ready = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
        model_reset();
        @(negedge clock); @(negedge clock);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
            instr_valid !== 1'b0 || err_misaligned !== 1'b0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_values got req=%b addr=%h instr=%h pc=%h v=%b err=%b cnt=%0d exp all zero",
                     imem_req, imem_addr, instr, instr_pc, instr_valid, err_misaligned, fetch_count);
        end
        imem_ack = 1'b0; instr_ready = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        lat = 1; xfers = 0;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'h0);
        checks++;
        if (xfers != 9) begin
            errors++;
            $display("FAIL seq_throughput got %0d transfers exp 9", xfers);
        end
    endtask

    task automatic test_back_to_back();
        lat = 0; xfers = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0);
        checks++;
        if (xfers < 9 || xfers > 10) begin
            errors++;
            $display("FAIL b2b_throughput got %0d transfers exp 9..10", xfers);
        end
    endtask

    task automatic test_hold();
        bit ok;
        logic [31:0] h_instr, h_pc, h_cnt;
        spurious = 1'b1;
        wait_hold(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_reach got timeout exp instr_valid"); end
        h_instr = instr; h_pc = instr_pc; h_cnt = fetch_count;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            checks++;
            if (instr !== h_instr || instr_pc !== h_pc || imem_req !== 1'b0 || fetch_count !== h_cnt || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable got instr=%h pc=%h req=%b cnt=%0d exp instr=%h pc=%h req=0 cnt=%0d",
                         instr, instr_pc, imem_req, fetch_count, h_instr, h_pc, h_cnt);
            end
        end
        spurious = 1'b0;
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== h_pc + 32'd4) begin
            errors++;
            $display("FAIL hold_release got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, h_pc + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        logic [31:0] old_addr;
        lat = 0;
        wait_hold(ok);
        lat = 3;
        step(1'b1, 1'b0, 32'h0);
        old_addr = imem_addr;
        step(1'b0, 1'b1, 32'h0000_0040);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (imem_addr !== old_addr) ok = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        checks++;
        if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL redirect_wait_addr got req=%b addr=%h exp req=1 addr=00000040", imem_req, imem_addr);
        end
        wait_hold(ok);
        checks++;
        if (instr_pc !== 32'h40 || instr !== mem_word(32'h40)) begin
            errors++;
            $display("FAIL redirect_wait_instr got pc=%h instr=%h exp pc=00000040 instr=%h", instr_pc, instr, mem_word(32'h40));
        end
    endtask

    task automatic test_hold_redirect();
        bit ok;
        logic [31:0] cnt;
        lat = 0;
        wait_hold(ok);
        cnt = fetch_count;
        step(1'b1, 1'b1, 32'h0000_0100);
        checks++;
        if (instr_valid !== 1'b0 || fetch_count !== cnt || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL hold_redirect got v=%b cnt=%0d req=%b addr=%h exp v=0 cnt=%0d req=1 addr=00000100",
                     instr_valid, fetch_count, imem_req, imem_addr, cnt);
        end
    endtask

    task automatic test_misaligned();
        bit ok;
        wait_hold(ok);
        step(1'b0, 1'b1, 32'h0000_0046);
        checks++;
        if (err_misaligned !== 1'b1 || imem_addr !== 32'h44) begin
            errors++;
            $display("FAIL misaligned got err=%b addr=%h exp err=1 addr=00000044", err_misaligned, imem_addr);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        checks++;
        if (err_misaligned !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_sticky got %b exp 1", err_misaligned);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        wait_hold(ok);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (imem_req === 1'b1 && imem_addr === 32'h0) ok = 1'b1;
            else step(1'b1, 1'b0, 32'h0);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pc_wrap got addr=%h exp 00000000", imem_addr);
        end
    endtask

    task automatic test_reset_mid_discard();
        bit ok;
        lat = 0;
        wait_hold(ok);
        lat = 3;
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        imem_ack = 1'b1; imem_data = 32'h1234_5678;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
            instr_valid !== 1'b0 || err_misaligned !== 1'b0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_discard got req=%b addr=%h instr=%h pc=%h v=%b err=%b cnt=%0d exp all zero",
                     imem_req, imem_addr, instr, instr_pc, instr_valid, err_misaligned, fetch_count);
        end
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack_ignored got req=%b v=%b exp req=0 v=0", imem_req, instr_valid);
        end
        imem_ack = 1'b0;
        model_reset();
        reset = 1'b0;
        lat = 1;
        wait_hold(ok);
        checks++;
        if (instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL restart got pc=%h instr=%h exp pc=00000000 instr=%h", instr_pc, instr, mem_word(32'h0));
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        bit rdy, rd;
        lat = -1; spurious = 1'b1; xfers = 0;
        for (int i = 0; i < 800; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0:       tgt = 32'hFFFF_FFFC;
                1:       tgt = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                default: tgt = 32'($urandom_range(0, 1023)) << 2;
            endcase
            step(rdy, rd, tgt);
        end
        spurious = 1'b0;
        checks++;
        if (xfers < 50) begin
            errors++;
            $display("FAIL random_progress got %0d transfers exp at least 50", xfers);
        end
    endtask

    initial begin
        lat = 1; spurious = 1'b0; pending = 1'b0; wait_c = 0; pend_addr = 32'h0; xfers = 0;
        test_reset();
        test_sequential();
        test_back_to_back();
        test_hold();
        test_redirect_wait();
        test_hold_redirect();
        test_misaligned();
        test_wrap();
        test_reset_mid_discard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
